// File: rtl/seg7_pkg.sv
// Shared constants and state encoding for the seven-segment scan controller.
// Glyphs are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment glyph; codes 10-15 render as a dash.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = 7'h40;
         4'd1:    seg_o = 7'h79;
         4'd2:    seg_o = 7'h24;
         4'd3:    seg_o = 7'h30;
         4'd4:    seg_o = 7'h19;
         4'd5:    seg_o = 7'h12;
         4'd6:    seg_o = 7'h02;
         4'd7:    seg_o = 7'h78;
         4'd8:    seg_o = 7'h00;
         4'd9:    seg_o = 7'h10;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of up to eight BCD digits onto one shared seg bus,
// with a blanking gap at each slot start, per-digit masking and leading-zero suppression.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int DIGITS    = 8,
   parameter int SCAN_DIV  = 10000,
   parameter int BLANK_CYC = 50
) (
   input  logic                  clk_in1,
   input  logic                  clr,
   input  logic                  Enable,
   input  logic [4*DIGITS-1:0]   bcd_all,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic                  lz_blank,
   output logic [7:0]            an,
   output logic [6:0]            seg,
   output logic [2:0]            address,
   output logic                  frame_done
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_SLOT_END  = CNT_W'(SCAN_DIV - 1);
   localparam logic [2:0]       ADDR_LAST     = 3'(DIGITS - 1);

   scan_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       addr_q, addr_d;
   logic [3:0]       digit_q, digit_d;
   logic             en_q, en_d;
   logic             hz_q, hz_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             frame_q, frame_d;

   logic [3:0]       sel_digit;
   logic             sel_en;
   logic             upper_nz;
   logic             sel_hz;
   logic [6:0]       glyph;

   // Pick the current slot's digit and check whether it or any higher digit is nonzero.
   always_comb begin
      sel_digit = 4'd0;
      sel_en    = 1'b0;
      upper_nz  = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (3'(i) == addr_q) begin
            sel_digit = bcd_all[4*i +: 4];
            sel_en    = digit_en[i];
         end
         if ((3'(i) >= addr_q) && (bcd_all[4*i +: 4] != 4'd0)) begin
            upper_nz = 1'b1;
         end
      end
      sel_hz = lz_blank && (addr_q != 3'd0) && !upper_nz;
   end

   always_ff @(posedge clk_in1 or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         digit_q <= '0;
         en_q    <= 1'b0;
         hz_q    <= 1'b0;
         an_q    <= AN_OFF;
         seg_q   <= SEG_BLANK;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         digit_q <= digit_d;
         en_q    <= en_d;
         hz_q    <= hz_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         frame_q <= frame_d;
      end
   end

   // Slot inputs are captured only on the BLANK->SHOW edge so mid-slot changes never glitch the glyph.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      digit_d = digit_q;
      en_d    = en_q;
      hz_d    = hz_q;
      if (!Enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         addr_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = BLANK;
               cnt_d   = '0;
               addr_d  = '0;
            end
            BLANK: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_BLANK_END) begin
                  state_d = SHOW;
                  digit_d = sel_digit;
                  en_d    = sel_en;
                  hz_d    = sel_hz;
               end
            end
            SHOW: begin
               if (cnt_q == CNT_SLOT_END) begin
                  state_d = BLANK;
                  cnt_d   = '0;
                  addr_d  = (addr_q == ADDR_LAST) ? 3'd0 : addr_q + 3'd1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               addr_d  = '0;
            end
         endcase
      end
   end

   seg7_decode u_decode (
      .bcd_i (digit_d),
      .seg_o (glyph)
   );

   // Outputs are computed from next-state values so the registered pins line up with the state edge.
   always_comb begin
      an_d    = AN_OFF;
      seg_d   = SEG_BLANK;
      frame_d = (state_q == SHOW) && (state_d == BLANK) && (addr_q == ADDR_LAST);
      if ((state_d == SHOW) && en_d && !hz_d) begin
         an_d[addr_d] = 1'b0;
         seg_d        = glyph;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign address    = addr_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with SCAN_DIV=20, BLANK_CYC=4,
// using an 8-digit instance and a 3-digit instance for the wrap case.
module tb_seg7_scan_ctrl;

   logic        clock;
   logic        reset;
   logic        enable;
   logic [31:0] bcdAll;
   logic [7:0]  digitEn;
   logic        lzBlank;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic [2:0]  address;
   logic        frameDone;

   logic        enable3;
   logic [11:0] bcd3;
   logic [2:0]  digitEn3;
   logic [7:0]  an3;
   logic [6:0]  seg3;
   logic [2:0]  address3;
   logic        frameDone3;

   int          testsRun;
   int          testsFailed;
   int          cyc;
   int          pulses;
   int          firstPulse;
   int          secondPulse;
   int          highViol;
   logic [7:0]  expAn  [8];
   logic [6:0]  expSeg [8];

   seg7_scan_ctrl #(.DIGITS(8), .SCAN_DIV(20), .BLANK_CYC(4)) dut (
      .clk_in1    (clock),
      .clr        (reset),
      .Enable     (enable),
      .bcd_all    (bcdAll),
      .digit_en   (digitEn),
      .lz_blank   (lzBlank),
      .an         (an),
      .seg        (seg),
      .address    (address),
      .frame_done (frameDone)
   );

   seg7_scan_ctrl #(.DIGITS(3), .SCAN_DIV(20), .BLANK_CYC(4)) dut3 (
      .clk_in1    (clock),
      .clr        (reset),
      .Enable     (enable3),
      .bcd_all    (bcd3),
      .digit_en   (digitEn3),
      .lz_blank   (1'b0),
      .an         (an3),
      .seg        (seg3),
      .address    (address3),
      .frame_done (frameDone3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic waitCyc(input int target);
      tick(target - cyc);
   endtask

   // Restart the 8-digit scan from IDLE with new inputs; cyc counts edges from the enabling edge.
   task automatic applyStimulus(input logic [7:0] en, input logic [31:0] bcd, input logic lz);
      enable = 1'b0;
      tick(1);
      digitEn = en;
      bcdAll  = bcd;
      lzBlank = lz;
      enable  = 1'b1;
      cyc     = 0;
   endtask

   // Sample the middle of each slot's SHOW phase against the expected tables.
   task automatic checkFrame();
      for (int k = 0; k < 8; k++) begin
         waitCyc(20*k + 10);
         checkOutput($sformatf("an slot%0d", k), {24'd0, an}, {24'd0, expAn[k]});
         checkOutput($sformatf("seg slot%0d", k), {25'd0, seg}, {25'd0, expSeg[k]});
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      cyc         = 0;
      reset       = 1'b1;
      enable      = 1'b0;
      bcdAll      = 32'h0;
      digitEn     = 8'h00;
      lzBlank     = 1'b0;
      enable3     = 1'b0;
      bcd3        = 12'h210;
      digitEn3    = 3'b111;

      tick(2);
      checkOutput("reset an", {24'd0, an}, 32'hFF);
      checkOutput("reset seg", {25'd0, seg}, 32'h7F);
      checkOutput("reset address", {29'd0, address}, 32'd0);
      checkOutput("reset frame_done", {31'd0, frameDone}, 32'd0);
      reset = 1'b0;
      tick(2);
      checkOutput("idle an", {24'd0, an}, 32'hFF);

      // First enable: slot 0 blanked for 4 cycles, then digit 0 shown.
      digitEn = 8'hFF;
      bcdAll  = 32'h76543210;
      lzBlank = 1'b0;
      enable  = 1'b1;
      cyc     = 0;
      waitCyc(1);
      checkOutput("first blank an", {24'd0, an}, 32'hFF);
      waitCyc(4);
      checkOutput("last blank an", {24'd0, an}, 32'hFF);
      waitCyc(5);
      checkOutput("slot0 an", {24'd0, an}, 32'hFE);
      checkOutput("slot0 seg", {25'd0, seg}, 32'h40);
      checkOutput("slot0 address", {29'd0, address}, 32'd0);
      waitCyc(20);
      checkOutput("slot0 end an", {24'd0, an}, 32'hFE);
      waitCyc(21);
      checkOutput("slot1 blank an", {24'd0, an}, 32'hFF);
      checkOutput("slot1 address", {29'd0, address}, 32'd1);
      waitCyc(25);
      checkOutput("slot1 an", {24'd0, an}, 32'hFD);
      checkOutput("slot1 seg", {25'd0, seg}, 32'h79);

      pulses      = 0;
      firstPulse  = 0;
      secondPulse = 0;
      while (cyc < 400) begin
         tick(1);
         if (frameDone) begin
            pulses++;
            if (firstPulse == 0) firstPulse = cyc;
            else if (secondPulse == 0) secondPulse = cyc;
         end
      end
      checkOutput("frame pulse count", pulses, 32'd2);
      checkOutput("first frame pulse", firstPulse, 32'd161);
      checkOutput("second frame pulse", secondPulse, 32'd321);

      // Leading-zero suppression: digit 1 is zero but digit 2 is not, so 0..2 show.
      applyStimulus(8'hFF, 32'h00000305, 1'b1);
      expAn  = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      expSeg = '{7'h12, 7'h40, 7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      checkFrame();

      applyStimulus(8'hFF, 32'h00000000, 1'b1);
      expAn  = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      expSeg = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      checkFrame();

      // Mask plus dash: only slots 1 and 3 enabled, digit 1 holds code C.
      applyStimulus(8'h0A, 32'h765432C0, 1'b0);
      expAn  = '{8'hFF, 8'hFD, 8'hFF, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      expSeg = '{7'h7F, 7'h3F, 7'h7F, 7'h30, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      checkFrame();
      waitCyc(160);
      checkOutput("mask frame_done early", {31'd0, frameDone}, 32'd0);
      waitCyc(161);
      checkOutput("mask frame_done", {31'd0, frameDone}, 32'd1);
      waitCyc(162);
      checkOutput("mask frame_done one cycle", {31'd0, frameDone}, 32'd0);

      // Mid-slot input change is ignored until the next latch point.
      applyStimulus(8'hFF, 32'h76543210, 1'b0);
      waitCyc(8);
      checkOutput("midslot seg before", {25'd0, seg}, 32'h40);
      bcdAll = 32'h76543219;
      waitCyc(12);
      checkOutput("midslot seg held", {25'd0, seg}, 32'h40);
      waitCyc(21);
      checkOutput("midslot blank seg", {25'd0, seg}, 32'h7F);
      waitCyc(165);
      checkOutput("next frame new glyph", {25'd0, seg}, 32'h10);
      checkOutput("next frame an", {24'd0, an}, 32'hFE);

      // Disable in slot 5, then re-enable from slot 0.
      applyStimulus(8'hFF, 32'h76543210, 1'b0);
      waitCyc(110);
      checkOutput("slot5 address", {29'd0, address}, 32'd5);
      checkOutput("slot5 an", {24'd0, an}, 32'hDF);
      checkOutput("slot5 seg", {25'd0, seg}, 32'h12);
      enable = 1'b0;
      tick(1);
      checkOutput("disable an", {24'd0, an}, 32'hFF);
      checkOutput("disable address", {29'd0, address}, 32'd0);
      checkOutput("disable seg", {25'd0, seg}, 32'h7F);
      enable = 1'b1;
      cyc    = 0;
      waitCyc(4);
      checkOutput("reenable blank an", {24'd0, an}, 32'hFF);
      waitCyc(5);
      checkOutput("reenable slot0 an", {24'd0, an}, 32'hFE);
      checkOutput("reenable address", {29'd0, address}, 32'd0);

      // Asynchronous clear between edges blanks immediately.
      waitCyc(10);
      checkOutput("pre-clr an", {24'd0, an}, 32'hFE);
      #2 reset = 1'b1;
      #1;
      checkOutput("async clr an", {24'd0, an}, 32'hFF);
      checkOutput("async clr seg", {25'd0, seg}, 32'h7F);
      checkOutput("async clr address", {29'd0, address}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      cyc   = 0;
      waitCyc(4);
      checkOutput("post-clr blank an", {24'd0, an}, 32'hFF);
      waitCyc(5);
      checkOutput("post-clr slot0 an", {24'd0, an}, 32'hFE);
      checkOutput("post-clr slot0 seg", {25'd0, seg}, 32'h40);

      // clr together with Enable low.
      enable = 1'b0;
      reset  = 1'b1;
      tick(1);
      checkOutput("clr+disable an", {24'd0, an}, 32'hFF);
      reset = 1'b0;
      tick(2);
      checkOutput("clr+disable idle frame_done", {31'd0, frameDone}, 32'd0);
      checkOutput("clr+disable idle address", {29'd0, address}, 32'd0);

      // Three-digit instance: address wraps 2->0, frame every 60 cycles.
      enable3     = 1'b1;
      cyc         = 0;
      pulses      = 0;
      firstPulse  = 0;
      secondPulse = 0;
      highViol    = 0;
      while (cyc < 130) begin
         tick(1);
         if (an3[7:3] !== 5'h1F) highViol++;
         if (frameDone3) begin
            pulses++;
            if (firstPulse == 0) firstPulse = cyc;
            else if (secondPulse == 0) secondPulse = cyc;
         end
         if (cyc == 10) checkOutput("d3 address slot0", {29'd0, address3}, 32'd0);
         if (cyc == 30) checkOutput("d3 address slot1", {29'd0, address3}, 32'd1);
         if (cyc == 50) begin
            checkOutput("d3 address slot2", {29'd0, address3}, 32'd2);
            checkOutput("d3 an slot2", {24'd0, an3}, 32'hFB);
            checkOutput("d3 seg slot2", {25'd0, seg3}, 32'h24);
         end
         if (cyc == 70) checkOutput("d3 address wrap", {29'd0, address3}, 32'd0);
      end
      checkOutput("d3 frame pulse count", pulses, 32'd2);
      checkOutput("d3 first frame pulse", firstPulse, 32'd61);
      checkOutput("d3 second frame pulse", secondPulse, 32'd121);
      checkOutput("d3 unused anodes high", highViol, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan scheduler for the board's 8-digit common-anode seven-segment display. It shares the single `seg` bus among eight BCD digit sources. Each digit gets a fixed slot with a ghost-suppression blanking gap, plus optional per-digit masking and leading-zero suppression. It runs in the 5 MHz clock-wizard domain and replaces the ad-hoc digit-toggle logic in the counter/stopwatch top levels.

## Interface
- `DIGITS`, 8: number of digit slots, 1..8.
- `SCAN_DIV`, 10000: clock cycles per digit slot (500 Hz slot rate at 5 MHz).
- `BLANK_CYC`, 50: cycles at slot start with all anodes off; requires 1 ≤ BLANK_CYC < SCAN_DIV.

Ports:
- `clk_in1`, in, 1: single clock; every flop is on its rising edge.
- `clr`, in, 1: reset, asynchronous and active-high.
- `Enable`, in, 1: scan enable; low forces IDLE.
- `bcd_all`, in, 4*DIGITS: packed digits; digit i is `bcd_all[4i+3:4i]`; digit 0 is rightmost/least significant.
- `digit_en`, in, DIGITS: per-digit show mask; 1 means shown.
- `lz_blank`, in, 1: leading-zero suppression enable.
- `an`, out, 8: anodes, active-low, one-hot-low or all-high; bits ≥ DIGITS are always 1.
- `seg`, out, 7: `{g,f,e,d,c,b,a}`, active-low.
- `address`, out, 3: index of the current slot.
- `frame_done`, out, 1: one-cycle pulse when slot DIGITS-1 ends.

## Operation
- FSM states:
  - IDLE: outputs blanked, address 0, prescaler 0.
  - BLANK: an=8'hFF, seg=7'h7F, for BLANK_CYC cycles.
  - SHOW: for SCAN_DIV−BLANK_CYC cycles.
- Transitions:
  - IDLE→BLANK on the first edge with Enable=1; address stays 0.
  - BLANK→SHOW after BLANK_CYC cycles. On this edge, latch digit value d, the show flag, and the higher-zero flag for `address` into holding registers. Mid-slot input changes have no effect.
  - SHOW→BLANK at the end of the slot. address becomes (address+1) mod DIGITS, wrapping DIGITS-1→0.
  - Any state→IDLE on an edge with Enable=0. Prescaler and address clear.
- Show rule for digit i:
  - Requires digit_en[i]=1.
  - Also requires NOT(lz_blank ∧ i≠0 ∧ digits i..DIGITS-1 all zero).
  - Digit 0 is never suppressed by lz_blank.
  - A masked or suppressed digit keeps its full slot with an=8'hFF (uniform brightness, fixed frame period).
- In SHOW with the digit shown: an[address]=0, others 1; seg=decode(d).
- Decode: 0–9 standard glyphs, e.g. 0→7'h40, 1→7'h79, 8→7'h00. Codes 10–15 give a dash (7'h3F).
- frame_done asserts for one cycle coincident with the SHOW→BLANK edge out of slot DIGITS-1. It never asserts in IDLE.

## Timing
- Reset values: an=8'hFF, seg=7'h7F, address=0, frame_done=0, state IDLE, prescaler 0.
- All outputs are registered and change only on `clk_in1` edges, or asynchronously to reset values on `clr`.
- First anode goes low BLANK_CYC+1 edges after the first Enable=1 edge.
- Slot period is exactly SCAN_DIV cycles; frame period is DIGITS·SCAN_DIV cycles (80000 at defaults, 16 ms).
- `clr` mid-slot: immediate blank. After deassertion, behaviour is identical to the Enable rising from IDLE.
- Enable=0 and clr simultaneous: clr wins; the result is the same state.
- Enable toggling 1→0→1 restarts at slot 0 with a fresh BLANK phase.

## Structure
- Shared package `seg7_pkg`:
  - glyph constants `SEG_BLANK=7'h7F` and `SEG_DASH=7'h3F`
  - state encoding IDLE/BLANK/SHOW
  - `AN_OFF=8'hFF`
- One combinational sub-module `seg7_decode`: 4-bit BCD in, active-low 7-bit glyph out.
- Prescaler width is $clog2(SCAN_DIV).

## Test plan
Scenarios use SCAN_DIV=20, BLANK_CYC=4, DIGITS=8 unless noted.
- Reset and enable: clr pulse, then Enable=1, digit_en=8'hFF, bcd_all=32'h76543210.
  - Before cycle 5: an=8'hFF.
  - Cycles 5–20: an=8'hFE, seg=7'h40.
  - Next slot: an=8'hFD, seg=7'h79.
  - frame_done pulses once every 160 cycles.
- Leading zero: bcd_all=32'h00000305, lz_blank=1.
  - Digits 0–2 are shown (digit 1 zero but digit 2 nonzero).
  - Digits 3–7 keep an=8'hFF.
  - bcd_all=0 shows only digit 0 as "0".
- Mask and dash: digit_en=8'h0A, digit 1 value 4'hC.
  - Only slots 1 and 3 drive an low.
  - Slot 1 seg=7'h3F.
  - Period stays 160 cycles.
- Mid-slot change: change bcd_all during a SHOW phase -> seg holds the latched glyph until the next BLANK.
- Disable/reset mid-slot:
  - Enable=0 at slot 5: next edge gives an=8'hFF, address=0; re-enable restarts at slot 0 after 4 blank cycles.
  - Async clr assertion between edges: outputs go to reset values immediately.
- Wrap with DIGITS=3: address sequence 0,1,2,0; frame_done every 60 cycles; an[7:3] always 1.
